lzc_pipe: RTL and testbench



---
 rtl/lzc_pkg.sv | 32 +++
 rtl/lzc_pipe_if.sv | 39 +++
 rtl/lzc_chunk.sv | 23 ++
 rtl/lzc_pipe.sv | 142 ++++++++++++++
 tb/tb_lzc_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lzc_pkg.sv
// rtl/lzc_pkg.sv - shared widths, helper functions and stage-1 result type for lzc_pipe
package lzc_pkg;

    localparam int DEF_WIDTH = 128;
    localparam int DEF_CHUNK = 16;
    localparam int NCH       = DEF_WIDTH / DEF_CHUNK;

    // Local-count field width in the stored chunk result; covers CHUNK up to 256.
    localparam int LCW_MAX = 8;

    function automatic int lzc_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Count width able to hold 0..w inclusive (w = all-zero word).
    function automatic int lzc_cw(input int w);
        return lzc_clog2(w + 1);
    endfunction

    // Local leading-zero count width for a w-bit chunk (0..w-1).
    function automatic int lzc_lcw(input int w);
        return lzc_clog2(w);
    endfunction

    typedef struct packed {
        logic               nz;
        logic [LCW_MAX-1:0] cnt;
    } chunk_res_t;

endpackage

// File: rtl/lzc_pipe_if.sv
// rtl/lzc_pipe_if.sv - word/result handshake bundle for lzc_pipe (out_norm under LZC_PIPE_NORM_EN)
interface lzc_pipe_if
    import lzc_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int TAG_W = 8,
    localparam int CW   = lzc_cw(WIDTH)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;
`ifdef LZC_PIPE_NORM_EN
    logic [WIDTH-1:0] out_norm;
`endif

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_count, out_zero, out_tag
`ifdef LZC_PIPE_NORM_EN
        , input out_norm
`endif
    );

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_count, out_zero, out_tag
`ifdef LZC_PIPE_NORM_EN
        , output out_norm
`endif
    );

endinterface

// File: rtl/lzc_chunk.sv
// rtl/lzc_chunk.sv - combinational CHUNK-bit leading-zero counter with nonzero flag
module lzc_chunk
    import lzc_pkg::*;
#(
    parameter int CHUNK = 16,
    localparam int LCW  = lzc_lcw(CHUNK)
) (
    input  logic [CHUNK-1:0] data,
    output logic             nz,
    output logic [LCW-1:0]   count
);

    assign nz = |data;

    // Scan LSB to MSB so the highest set bit is written last and wins; zero chunk reports 0.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (data[i]) count = LCW'(CHUNK - 1 - i);
        end
    end

endmodule

// File: rtl/lzc_pipe.sv
// rtl/lzc_pipe.sv - two-stage pipelined leading-zero counter; LZC_PIPE_NORM_EN adds out_norm
module lzc_pipe
    import lzc_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int CHUNK = 16,
    parameter int TAG_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    lzc_pipe_if.slave  bus
);

    localparam int N_CH = WIDTH / CHUNK;
    localparam int CW   = lzc_cw(WIDTH);
    localparam int LCW  = lzc_lcw(CHUNK);

    // Chunk 0 is the most significant chunk; packed index g holds chunk g.
    chunk_res_t [N_CH-1:0] c_res;

    logic                  s1_valid;
    chunk_res_t [N_CH-1:0] s1_res;
    logic [TAG_W-1:0]      s1_tag;
`ifdef LZC_PIPE_NORM_EN
    logic [WIDTH-1:0]      s1_data;
    logic [WIDTH-1:0]      s2_norm;
    logic [WIDTH-1:0]      next_norm;
`endif

    logic                  s2_valid;
    logic [CW-1:0]         s2_count;
    logic                  s2_zero;
    logic [TAG_W-1:0]      s2_tag;

    logic                  s2_load;
    logic                  s1_load;
    logic                  in_fire;

    logic                  found;
    logic [CW-1:0]         k_sel;
    logic [CW-1:0]         next_count;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_chunk
            logic           nz;
            logic [LCW-1:0] cnt;

            lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
                .data  (bus.in_data[WIDTH-1-g*CHUNK -: CHUNK]),
                .nz    (nz),
                .count (cnt)
            );

            assign c_res[g].nz  = nz;
            assign c_res[g].cnt = LCW_MAX'(cnt);
        end
    endgenerate

    // A stage refills when it is empty or its contents move on this cycle.
    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign in_fire      = bus.in_valid && s1_load;
    assign bus.in_ready = s1_load;

    // Pick the most significant nonzero chunk: scanning upward lets the lowest index win.
    always_comb begin
        found      = 1'b0;
        k_sel      = '0;
        next_count = CW'(WIDTH);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s1_res[i].nz) begin
                found = 1'b1;
                k_sel = CW'(i);
            end
        end
        if (found) begin
            next_count = (k_sel << LCW) + CW'(s1_res[k_sel].cnt);
        end
    end

`ifdef LZC_PIPE_NORM_EN
    // Normalise by the final count; an all-zero word stays zero.
    always_comb begin
        next_norm = '0;
        if (found) next_norm = s1_data << next_count;
    end
`endif

    // Stage 1: capture per-chunk flags/counts and the tag on an accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_tag   <= '0;
`ifdef LZC_PIPE_NORM_EN
            s1_data  <= '0;
`endif
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (in_fire) begin
                s1_res <= c_res;
                s1_tag <= bus.in_tag;
`ifdef LZC_PIPE_NORM_EN
                s1_data <= bus.in_data;
`endif
            end
        end
    end

    // Stage 2: combine chunk results into the final count; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_count <= '0;
            s2_zero  <= 1'b0;
            s2_tag   <= '0;
`ifdef LZC_PIPE_NORM_EN
            s2_norm  <= '0;
`endif
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_count <= next_count;
                s2_zero  <= !found;
                s2_tag   <= s1_tag;
`ifdef LZC_PIPE_NORM_EN
                s2_norm  <= next_norm;
`endif
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_count = s2_count;
    assign bus.out_zero  = s2_zero;
    assign bus.out_tag   = s2_tag;
`ifdef LZC_PIPE_NORM_EN
    assign bus.out_norm  = s2_norm;
`endif

endmodule

// File: tb/tb_lzc_pipe.sv
// tb/tb_lzc_pipe.sv - self-checking bench for lzc_pipe (checks out_norm when LZC_PIPE_NORM_EN is defined)
module tb_lzc_pipe;

    localparam int W = 128;

    typedef struct {
        logic [W-1:0] data;
        logic [7:0]   tag;
    } item_t;

    typedef struct {
        logic [W-1:0] data;
        logic [7:0]   tag;
        int           count;
        logic         zero;
        logic [W-1:0] norm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    item_t src_q[$];
    item_t exp_q[$];
    vec_t  tbl[8];

    lzc_pipe_if #(.WIDTH(W), .TAG_W(8)) bus ();

    lzc_pipe #(.WIDTH(W), .CHUNK(16), .TAG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int ref_lzc(input logic [W-1:0] d);
        for (int i = W - 1; i >= 0; i--) begin
            if (d[i]) return W - 1 - i;
        end
        return W;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        int           sh;
        r  = {$urandom(), $urandom(), $urandom(), $urandom()};
        sh = $urandom_range(0, W);
        if (sh == W) return '0;
        r[W-1] = 1'b1;
        if ($urandom_range(0, 3) == 0) r = {1'b1, {(W-1){1'b0}}};
        return r >> sh;
    endfunction

    task automatic check_result(input string nm, input item_t it);
        int c;
        c = ref_lzc(it.data);
        chk({nm, ".count"}, W'(bus.out_count), W'(c));
        chk({nm, ".zero"}, W'(bus.out_zero), W'(c == W));
        chk({nm, ".tag"}, W'(bus.out_tag), W'(it.tag));
`ifdef LZC_PIPE_NORM_EN
        chk({nm, ".norm"}, bus.out_norm, (c == W) ? '0 : (it.data << c));
`endif
    endtask

    // mode 0: random in_valid gaps and out_ready; mode 1: out_ready low for first 5 cycles
    task automatic run_stream(input int mode, input int max_cycles, input string nm);
        int           cyc;
        logic         hold_v;
        logic         fire_in;
        logic [7:0]   h_count;
        logic         h_zero;
        logic [7:0]   h_tag;
`ifdef LZC_PIPE_NORM_EN
        logic [W-1:0] h_norm;
        h_norm = '0;
`endif
        cyc    = 0;
        hold_v = 1'b0;
        h_count = '0;
        h_zero  = 1'b0;
        h_tag   = '0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
            @(negedge clk);
            bus.out_ready = (mode == 1) ? (cyc >= 5) : ($urandom_range(0, 3) != 0);
            if (src_q.size() > 0 && (mode == 1 || $urandom_range(0, 4) != 0)) begin
                bus.in_valid = 1'b1;
                bus.in_data  = src_q[0].data;
                bus.in_tag   = src_q[0].tag;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = rand_word();
                bus.in_tag   = 8'($urandom());
            end
            #1;
            if (hold_v) begin
                chk({nm, ".hold_valid"}, W'(bus.out_valid), W'(1));
                chk({nm, ".hold_count"}, W'(bus.out_count), W'(h_count));
                chk({nm, ".hold_zero"}, W'(bus.out_zero), W'(h_zero));
                chk({nm, ".hold_tag"}, W'(bus.out_tag), W'(h_tag));
`ifdef LZC_PIPE_NORM_EN
                chk({nm, ".hold_norm"}, bus.out_norm, h_norm);
`endif
            end
            if (mode == 1 && cyc >= 2 && cyc <= 4) begin
                chk({nm, ".in_ready_stalled"}, W'(bus.in_ready), W'(0));
                chk({nm, ".accepted_stalled"}, W'(exp_q.size()), W'(2));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({nm, ".spurious_output"}, W'(1), W'(0));
                end else begin
                    check_result(nm, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            hold_v  = bus.out_valid && !bus.out_ready;
            h_count = bus.out_count;
            h_zero  = bus.out_zero;
            h_tag   = bus.out_tag;
`ifdef LZC_PIPE_NORM_EN
            h_norm  = bus.out_norm;
`endif
            fire_in = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (fire_in) exp_q.push_back(src_q.pop_front());
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({nm, ".drained"}, W'(src_q.size() + exp_q.size()), W'(0));
        src_q.delete();
        exp_q.delete();
    endtask

    initial begin
        item_t it;

        tbl[0] = '{{1'b1, 127'b0}, 8'h11, 0, 1'b0, {1'b1, 127'b0}};
        tbl[1] = '{128'h1, 8'h22, 127, 1'b0, {1'b1, 127'b0}};
        tbl[2] = '{128'h0, 8'h33, 128, 1'b1, 128'h0};
        tbl[3] = '{{128{1'b1}}, 8'h44, 0, 1'b0, {128{1'b1}}};
        tbl[4] = '{128'h1 << 112, 8'h55, 15, 1'b0, {1'b1, 127'b0}};
        tbl[5] = '{128'h1 << 111, 8'h66, 16, 1'b0, {1'b1, 127'b0}};
        tbl[6] = '{128'h3 << 16, 8'h77, 110, 1'b0, {2'b11, 126'b0}};
        tbl[7] = '{128'h1 << 15, 8'h88, 112, 1'b0, {1'b1, 127'b0}};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset.out_valid", W'(bus.out_valid), W'(0));
        chk("reset.out_count", W'(bus.out_count), W'(0));
        chk("reset.out_zero", W'(bus.out_zero), W'(0));
        chk("reset.out_tag", W'(bus.out_tag), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.in_ready", W'(bus.in_ready), W'(1));

        // table vectors, one at a time, latency checked
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = tbl[i].data;
            bus.in_tag   = tbl[i].tag;
            chk($sformatf("tbl%0d.in_ready", i), W'(bus.in_ready), W'(1));
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk($sformatf("tbl%0d.valid_cycle1", i), W'(bus.out_valid), W'(0));
            @(negedge clk);
            chk($sformatf("tbl%0d.valid_cycle2", i), W'(bus.out_valid), W'(1));
            chk($sformatf("tbl%0d.count", i), W'(bus.out_count), W'(tbl[i].count));
            chk($sformatf("tbl%0d.zero", i), W'(bus.out_zero), W'(tbl[i].zero));
            chk($sformatf("tbl%0d.tag", i), W'(bus.out_tag), W'(tbl[i].tag));
`ifdef LZC_PIPE_NORM_EN
            chk($sformatf("tbl%0d.norm", i), bus.out_norm, tbl[i].norm);
`endif
        end

        // back-to-back: 1<<100 then 1<<15
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h1 << 100;
        bus.in_tag   = 8'hA1;
        @(negedge clk);
        bus.in_data  = 128'h1 << 15;
        bus.in_tag   = 8'hA2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("b2b.first_valid", W'(bus.out_valid), W'(1));
        chk("b2b.first_count", W'(bus.out_count), W'(27));
        chk("b2b.first_tag", W'(bus.out_tag), W'(8'hA1));
        @(negedge clk);
        chk("b2b.second_valid", W'(bus.out_valid), W'(1));
        chk("b2b.second_count", W'(bus.out_count), W'(112));
        chk("b2b.second_tag", W'(bus.out_tag), W'(8'hA2));
        @(negedge clk);
        chk("b2b.idle", W'(bus.out_valid), W'(0));

        // backpressure: 4 words, out_ready low for 5 cycles
        for (int i = 0; i < 4; i++) begin
            it.data = rand_word();
            it.tag  = 8'(8'hB0 + i);
            src_q.push_back(it);
        end
        run_stream(1, 200, "bp");

        // randomized stream against the reference model
        for (int i = 0; i < 300; i++) begin
            it.data = rand_word();
            it.tag  = 8'($urandom());
            src_q.push_back(it);
        end
        run_stream(0, 5000, "rnd");

        // asynchronous reset with two words in flight
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 128'h1 << 50;
        bus.in_tag    = 8'hC1;
        @(negedge clk);
        bus.in_data   = 128'h1 << 60;
        bus.in_tag    = 8'hC2;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        chk("rst.inflight_valid", W'(bus.out_valid), W'(1));
        rst_n = 1'b0;
        #1;
        chk("rst.out_valid", W'(bus.out_valid), W'(0));
        chk("rst.out_count", W'(bus.out_count), W'(0));
        chk("rst.out_tag", W'(bus.out_tag), W'(0));
        chk("rst.in_ready", W'(bus.in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rst.no_stale%0d", i), W'(bus.out_valid), W'(0));
        end
        chk("rst.in_ready_after", W'(bus.in_ready), W'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
